// File: rtl/data_sram_if.sv
// data_sram_if: request/response bundle between the memory stage of the
// core (master) and the on-chip data SRAM (slave).
//   mem_en      request valid this cycle
//   mem_wen     byte-lane write enables (all zero = read)
//   mem_addr    byte address, bits [1:0] ignored by the memory
//   mem_wdata   lane-aligned write data
//   mem_rdata   read data, holds between read returns
//   rdata_valid one-cycle pulse per returned read
//   range_error one-cycle pulse for an out-of-range request
interface data_sram_if;
  logic        mem_en;
  logic [3:0]  mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        rdata_valid;
  logic        range_error;

  modport master (
    output mem_en, mem_wen, mem_addr, mem_wdata,
    input  mem_rdata, rdata_valid, range_error
  );

  modport slave (
    input  mem_en, mem_wen, mem_addr, mem_wdata,
    output mem_rdata, rdata_valid, range_error
  );
endinterface

// File: rtl/data_sram.sv
// data_sram: synchronous single-port 32-bit data RAM with byte-lane writes,
// a READ_LATENCY-deep fully pipelined read return and out-of-range reporting.
// Ports:
//   clk  - clock, all state on the rising edge
//   rst  - asynchronous active-low reset (array contents are not reset)
//   bus  - data_sram_if.slave: mem_en/mem_wen/mem_addr/mem_wdata in,
//          mem_rdata/rdata_valid/range_error out
// Parameters:
//   ADDR_WIDTH   word-address bits, capacity 2^ADDR_WIDTH words (<= 30)
//   READ_LATENCY cycles from read issue edge to rdata_valid, 1..4
//   BASE_ADDR    byte address of word 0, 4-byte aligned
module data_sram #(
  parameter int          ADDR_WIDTH   = 12,
  parameter int          READ_LATENCY = 1,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000
) (
  input logic         clk,
  input logic         rst,
  data_sram_if.slave  bus
);

  localparam int          DEPTH = 1 << ADDR_WIDTH;
  // Window size in bytes; one extra bit so the compare stays exact for wide arrays.
  localparam logic [32:0] SPAN  = 33'd4 << ADDR_WIDTH;

  logic [31:0]           off;
  logic                  in_range;
  logic [ADDR_WIDTH-1:0] idx;
  logic                  req;
  logic                  wr_fire;
  logic                  rd_fire;
  logic [31:0]           rd_word;

  // Wrapping subtract: addresses below BASE_ADDR land far above SPAN.
  assign off      = bus.mem_addr - BASE_ADDR;
  assign in_range = ({1'b0, off} < SPAN);
  assign idx      = off[ADDR_WIDTH+1:2];

  // Requests seen while reset is held are ignored so nothing lands in the array.
  assign req     = bus.mem_en && rst;
  assign wr_fire = req && (bus.mem_wen != 4'b0000);
  assign rd_fire = req && (bus.mem_wen == 4'b0000);

  logic [31:0] mem_q [DEPTH];

  // Array has no reset: contents survive rst and are undefined at power-up.
  always_ff @(posedge clk) begin
    if (wr_fire && in_range) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.mem_wen[i]) begin
          mem_q[idx][8*i +: 8] <= bus.mem_wdata[8*i +: 8];
        end
      end
    end
  end

  // Out-of-range reads return zero instead of aliasing into the array.
  assign rd_word = in_range ? mem_q[idx] : 32'h0000_0000;

  // Read return pipeline. Stage 0 captures the array at the issue edge, so a
  // later write can never disturb an in-flight read. Each stage loads only when
  // its upstream stage carries a valid read, which makes the last stage hold
  // its value between returns.
  logic        vld_q [READ_LATENCY];
  logic        vld_d [READ_LATENCY];
  logic [31:0] dat_q [READ_LATENCY];
  logic [31:0] dat_d [READ_LATENCY];
  logic        range_err_q;
  logic        range_err_d;

  always_comb begin
    for (int k = 0; k < READ_LATENCY; k++) begin
      vld_d[k] = 1'b0;
      dat_d[k] = dat_q[k];
    end
    vld_d[0] = rd_fire;
    if (rd_fire) begin
      dat_d[0] = rd_word;
    end
    for (int k = 1; k < READ_LATENCY; k++) begin
      vld_d[k] = vld_q[k-1];
      if (vld_q[k-1]) begin
        dat_d[k] = dat_q[k-1];
      end
    end
    range_err_d = req && !in_range;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < READ_LATENCY; k++) begin
        vld_q[k] <= 1'b0;
        dat_q[k] <= 32'h0000_0000;
      end
      range_err_q <= 1'b0;
    end else begin
      for (int k = 0; k < READ_LATENCY; k++) begin
        vld_q[k] <= vld_d[k];
        dat_q[k] <= dat_d[k];
      end
      range_err_q <= range_err_d;
    end
  end

  assign bus.mem_rdata   = dat_q[READ_LATENCY-1];
  assign bus.rdata_valid = vld_q[READ_LATENCY-1];
  assign bus.range_error = range_err_q;

endmodule

// File: tb/tb_data_sram.sv
module tb_data_sram;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  data_sram_if bus1 ();
  data_sram_if bus3 ();

  data_sram #(.ADDR_WIDTH(12), .READ_LATENCY(1), .BASE_ADDR(32'h0000_0000)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  data_sram #(.ADDR_WIDTH(12), .READ_LATENCY(3), .BASE_ADDR(32'h0000_1000)) u_dut3 (
    .clk (clk),
    .rst (rst),
    .bus (bus3)
  );

  typedef struct {
    int          cyc;
    logic [31:0] data;
  } exp_t;

  exp_t rq [2][$];
  int   eq [2][$];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int lat(int sel);
    return (sel == 0) ? 1 : 3;
  endfunction

  task automatic drive(int sel, logic en, logic [3:0] wen, logic [31:0] addr, logic [31:0] wdata);
    @(posedge clk);
    #1;
    bus1.mem_en = 1'b0;
    bus3.mem_en = 1'b0;
    if (sel == 0) begin
      bus1.mem_en = en; bus1.mem_wen = wen; bus1.mem_addr = addr; bus1.mem_wdata = wdata;
    end else begin
      bus3.mem_en = en; bus3.mem_wen = wen; bus3.mem_addr = addr; bus3.mem_wdata = wdata;
    end
  endtask

  // The request driven here is sampled on the next rising edge, numbered cyc+1.
  task automatic wr(int sel, logic [31:0] addr, logic [3:0] wen, logic [31:0] wdata, bit oor);
    drive(sel, 1'b1, wen, addr, wdata);
    if (oor) eq[sel].push_back(cyc + 1);
  endtask

  task automatic rd(int sel, logic [31:0] addr, logic [31:0] exp, bit oor);
    exp_t e;
    drive(sel, 1'b1, 4'b0000, addr, 32'h0);
    e.cyc  = cyc + lat(sel);
    e.data = exp;
    rq[sel].push_back(e);
    if (oor) eq[sel].push_back(cyc + 1);
  endtask

  task automatic idle(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      bus1.mem_en = 1'b0;
      bus3.mem_en = 1'b0;
    end
  endtask

  task automatic mon(int sel, logic v, logic [31:0] d, logic re);
    exp_t e;
    int   ec;
    while (rq[sel].size() > 0 && rq[sel][0].cyc < cyc) begin
      e = rq[sel].pop_front();
      total++; bad++;
      $display("FAIL rd_missing dut%0d: got no valid at cycle %0d expected data %h", sel, e.cyc, e.data);
    end
    while (eq[sel].size() > 0 && eq[sel][0] < cyc) begin
      ec = eq[sel].pop_front();
      total++; bad++;
      $display("FAIL err_missing dut%0d: got no range_error at cycle %0d expected pulse", sel, ec);
    end
    if (v === 1'b1) begin
      if (rq[sel].size() == 0) begin
        total++; bad++;
        $display("FAIL rd_unexpected dut%0d: got valid data %h at cycle %0d expected none", sel, d, cyc);
      end else begin
        e = rq[sel].pop_front();
        check($sformatf("rd_cycle dut%0d", sel), cyc, e.cyc);
        check($sformatf("rd_data dut%0d", sel), d, e.data);
      end
    end
    if (re === 1'b1) begin
      if (eq[sel].size() == 0) begin
        total++; bad++;
        $display("FAIL err_unexpected dut%0d: got range_error at cycle %0d expected none", sel, cyc);
      end else begin
        ec = eq[sel].pop_front();
        check($sformatf("err_cycle dut%0d", sel), cyc, ec);
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, bus1.rdata_valid, bus1.mem_rdata, bus1.range_error);
    mon(1, bus3.rdata_valid, bus3.mem_rdata, bus3.range_error);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected test end");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    bus1.mem_en = 0; bus1.mem_wen = 0; bus1.mem_addr = 0; bus1.mem_wdata = 0;
    bus3.mem_en = 0; bus3.mem_wen = 0; bus3.mem_addr = 0; bus3.mem_wdata = 0;
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rdata1", bus1.mem_rdata, 32'h0);
    check("rst_valid1", {31'b0, bus1.rdata_valid}, 32'h0);
    check("rst_err1",   {31'b0, bus1.range_error}, 32'h0);
    check("rst_rdata3", bus3.mem_rdata, 32'h0);
    check("rst_valid3", {31'b0, bus3.rdata_valid}, 32'h0);
    check("rst_err3",   {31'b0, bus3.range_error}, 32'h0);
    rst = 1'b1;

    // Latency 1: full word write then read-after-write
    wr(0, 32'h10, 4'b1111, 32'hDEADBEEF, 0);
    rd(0, 32'h10, 32'hDEADBEEF, 0);
    // Byte and halfword lane merges
    wr(0, 32'h10, 4'b0100, 32'h00AB0000, 0);
    rd(0, 32'h10, 32'hDEABBEEF, 0);
    wr(0, 32'h10, 4'b1100, 32'h12340000, 0);
    rd(0, 32'h10, 32'h1234BEEF, 0);
    // Out of range write must not alias onto word 0
    wr(0, 32'h0, 4'b1111, 32'h11111111, 0);
    wr(0, 32'h4000, 4'b1111, 32'hCAFEF00D, 1);
    rd(0, 32'h0, 32'h11111111, 0);
    rd(0, 32'h4000, 32'h0, 1);
    // mem_en low ignores mem_wen
    drive(0, 1'b0, 4'b1111, 32'h0, 32'hFFFFFFFF);
    rd(0, 32'h0, 32'h11111111, 0);
    // Top word, and misaligned address maps to its word
    wr(0, 32'h3FFC, 4'b1111, 32'hA5A5_5A5A, 0);
    rd(0, 32'h3FFC, 32'hA5A5_5A5A, 0);
    rd(0, 32'h12, 32'h1234BEEF, 0);
    idle(4);
    check("rdata_hold1", bus1.mem_rdata, 32'h1234BEEF);

    // Latency 3, base 0x1000: pipelined reads, later write does not disturb them
    wr(1, 32'h1000, 4'b1111, 32'h1, 0);
    wr(1, 32'h1004, 4'b1111, 32'h2, 0);
    wr(1, 32'h1008, 4'b1111, 32'h3, 0);
    rd(1, 32'h1000, 32'h1, 0);
    rd(1, 32'h1004, 32'h2, 0);
    rd(1, 32'h1008, 32'h3, 0);
    wr(1, 32'h1000, 4'b1111, 32'h99, 0);
    rd(1, 32'h1000, 32'h99, 0);
    // Below base wraps out of range, base+0x4000 out of range, last word in range
    rd(1, 32'h0FFC, 32'h0, 1);
    rd(1, 32'h5000, 32'h0, 1);
    wr(1, 32'h4FFC, 4'b0011, 32'h0000_BEEF, 0);
    wr(1, 32'h4FFC, 4'b1100, 32'hFACE_0000, 0);
    rd(1, 32'h4FFC, 32'hFACE_BEEF, 0);
    idle(6);
    check("rdata_hold3", bus3.mem_rdata, 32'hFACE_BEEF);

    // Reset with two reads in flight: they must never return
    rd(1, 32'h1004, 32'h2, 0);
    rd(1, 32'h1008, 32'h3, 0);
    @(posedge clk);
    #1;
    bus3.mem_en = 1'b0;
    rst = 1'b0;
    rq[1].delete();
    eq[1].delete();
    #1;
    check("midrst_valid3", {31'b0, bus3.rdata_valid}, 32'h0);
    check("midrst_rdata3", bus3.mem_rdata, 32'h0);
    @(posedge clk);
    #1;
    check("midrst_valid3_b", {31'b0, bus3.rdata_valid}, 32'h0);
    rst = 1'b1;
    idle(5);
    check("postrst_rdata3", bus3.mem_rdata, 32'h0);
    rd(1, 32'h1004, 32'h2, 0);
    rd(1, 32'h1008, 32'h3, 0);
    idle(8);

    check("rq_drained1", rq[0].size(), 32'd0);
    check("rq_drained3", rq[1].size(), 32'd0);
    check("eq_drained1", eq[0].size(), 32'd0);
    check("eq_drained3", eq[1].size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
